// File: rtl/vector_mem_transfer.sv
// rtl/vector_mem_transfer.sv - memory <-> vector register transfer sequencer (16-beat LOAD/STORE)
module vector_mem_transfer #(
    parameter int WORD_W         = 32,
    parameter int VEC_W          = 512,
    parameter int ADDR_W         = 9,
    parameter int RADDR_W        = 2,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_store,
    input  logic [ADDR_W-1:0]  base_address,
    input  logic [RADDR_W-1:0] reg_address,
    input  logic [VEC_W-1:0]   reg_rdata,
    input  logic [WORD_W-1:0]  mem_data_out,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_read_enable,
    output logic               mem_write_enable,
    output logic [WORD_W-1:0]  mem_data_in,
    output logic               reg_we,
    output logic [RADDR_W-1:0] reg_waddr,
    output logic [VEC_W-1:0]   reg_wdata,
    output logic               busy,
    output logic               done
);
    localparam int BEATS  = VEC_W / WORD_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LAT    = MEM_RD_LATENCY;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_LOAD_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_inc;
    logic [ADDR_W-1:0]   base_q;
    logic [RADDR_W-1:0]  raddr_q;
    logic [VEC_W-1:0]    vec_buf;
    logic [VEC_W-1:0]    buf_next;

    // Read-return tracker: stage LAT-1 is valid in the cycle mem_data_out holds that beat.
    logic [LAT-1:0]      rd_vld;
    logic [BEAT_W-1:0]   rd_idx [LAT];

    logic                cap_en;
    logic [BEAT_W-1:0]   cap_idx;
    logic                last_cap;

    assign beat_inc = beat + BEAT_W'(1);

    always_comb begin
        cap_en   = rd_vld[LAT-1];
        cap_idx  = rd_idx[LAT-1];
        buf_next = vec_buf;
        if (cap_en) begin
            buf_next[int'(cap_idx)*WORD_W +: WORD_W] = mem_data_out;
        end
        last_cap = cap_en && (cap_idx == LAST_BEAT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            beat             <= '0;
            base_q           <= '0;
            raddr_q          <= '0;
            vec_buf          <= '0;
            rd_vld           <= '0;
            for (int k = 0; k < LAT; k++) begin
                rd_idx[k] <= '0;
            end
            mem_address      <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_data_in      <= '0;
            reg_we           <= 1'b0;
            reg_waddr        <= '0;
            reg_wdata        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            rd_vld[0] <= mem_read_enable;
            rd_idx[0] <= beat;
            for (int k = 1; k < LAT; k++) begin
                rd_vld[k] <= rd_vld[k-1];
                rd_idx[k] <= rd_idx[k-1];
            end
            vec_buf <= buf_next;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base_address;
                        raddr_q     <= reg_address;
                        beat        <= '0;
                        busy        <= 1'b1;
                        mem_address <= base_address;
                        if (op_store) begin
                            vec_buf          <= reg_rdata;
                            mem_data_in      <= reg_rdata[WORD_W-1:0];
                            mem_write_enable <= 1'b1;
                            state            <= S_STORE;
                        end else begin
                            mem_read_enable <= 1'b1;
                            state           <= S_LOAD;
                        end
                    end
                end
                S_STORE: begin
                    if (beat == LAST_BEAT) begin
                        mem_write_enable <= 1'b0;
                        mem_address      <= '0;
                        mem_data_in      <= '0;
                        done             <= 1'b1;
                        state            <= S_DONE;
                    end else begin
                        beat        <= beat_inc;
                        mem_address <= base_q + ADDR_W'(beat_inc);
                        mem_data_in <= vec_buf[int'(beat_inc)*WORD_W +: WORD_W];
                    end
                end
                S_LOAD: begin
                    if (beat == LAST_BEAT) begin
                        mem_read_enable <= 1'b0;
                        mem_address     <= '0;
                        state           <= S_LOAD_DRAIN;
                    end else begin
                        beat        <= beat_inc;
                        mem_address <= base_q + ADDR_W'(beat_inc);
                    end
                end
                S_LOAD_DRAIN: begin
                    // Write back in the cycle after the final word lands, including that word.
                    if (last_cap) begin
                        reg_we    <= 1'b1;
                        reg_waddr <= raddr_q;
                        reg_wdata <= buf_next;
                        done      <= 1'b1;
                        state     <= S_WB;
                    end
                end
                S_WB: begin
                    reg_we <= 1'b0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    beat   <= '0;
                    state  <= S_IDLE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    beat  <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mem_transfer.sv
// tb/tb_vector_mem_transfer.sv - bench for vector_mem_transfer against a word-array memory model
module tb_vector_mem_transfer;
    localparam int W  = 32;
    localparam int V  = 512;
    localparam int AW = 9;
    localparam int RW = 2;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op_store;
    logic [AW-1:0] base_address;
    logic [RW-1:0] reg_address;
    logic [V-1:0]  reg_rdata;
    logic [W-1:0]  mem_data_out;
    logic [AW-1:0] mem_address;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [W-1:0]  mem_data_in;
    logic          reg_we;
    logic [RW-1:0] reg_waddr;
    logic [V-1:0]  reg_wdata;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem [512];
    logic [W-1:0]  ref_mem [512];
    int            write_cnt = 0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [W-1:0]  pl_data = '0;

    int errors = 0;
    int checks = 0;

    vector_mem_transfer dut (
        .clk(clk), .reset(reset), .start(start), .op_store(op_store),
        .base_address(base_address), .reg_address(reg_address), .reg_rdata(reg_rdata),
        .mem_data_out(mem_data_out), .mem_address(mem_address),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one-cycle read latency plus a backdoor preload port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] = pl_data;
        if (mem_write_enable) begin
            mem[mem_address] = mem_data_in;
            write_cnt = write_cnt + 1;
        end
        if (mem_read_enable) mem_data_out <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string t, input bit re, input bit we, input bit rwe,
                              input bit dn, input bit bsy);
        chk({t, ".re"},   V'(mem_read_enable),  V'(re));
        chk({t, ".we"},   V'(mem_write_enable), V'(we));
        chk({t, ".rwe"},  V'(reg_we),           V'(rwe));
        chk({t, ".done"}, V'(done),             V'(dn));
        chk({t, ".busy"}, V'(busy),             V'(bsy));
    endtask

    task automatic expect_zero(input string t);
        expect_out(t, 0, 0, 0, 0, 0);
        chk({t, ".addr"},  V'(mem_address), '0);
        chk({t, ".din"},   V'(mem_data_in), '0);
        chk({t, ".waddr"}, V'(reg_waddr),   '0);
        chk({t, ".wdata"}, reg_wdata,       '0);
    endtask

    function automatic logic [V-1:0] rand_vec();
        logic [V-1:0] v;
        for (int i = 0; i < NB; i++) v[W*i +: W] = $urandom;
        return v;
    endfunction

    function automatic int wrap(input logic [AW-1:0] base, input int i);
        return (int'(base) + i) % 512;
    endfunction

    task automatic poke(input int addr, input logic [W-1:0] data);
        pl_addr = AW'(addr);
        pl_data = data;
        pl_en   = 1'b1;
        ref_mem[addr] = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Called just after a negedge with the DUT idle; returns at the negedge of cycle 18.
    task automatic do_store(input logic [AW-1:0] base, input logic [V-1:0] vec, input bit pulses);
        int wc0;
        string t;
        logic [V-1:0] obsv;
        op_store = 1'b1; base_address = base; reg_rdata = vec; reg_address = RW'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; reg_rdata = rand_vec(); base_address = AW'($urandom); op_store = 1'b0;
        wc0 = write_cnt;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            t = $sformatf("st_b%0h_c%0d", base, k);
            if (k <= 16) begin
                expect_out(t, 0, 1, 0, 0, 1);
                chk({t, ".addr"}, V'(mem_address), V'(wrap(base, k - 1)));
                chk({t, ".din"},  V'(mem_data_in), V'(vec[W*(k-1) +: W]));
            end else if (k == 17) begin
                expect_out(t, 0, 0, 0, 1, 1);
            end else begin
                expect_out(t, 0, 0, 0, 0, 0);
            end
            start = pulses && (k == 5 || k == 17);
        end
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            ref_mem[wrap(base, i)] = vec[W*i +: W];
            obsv[W*i +: W] = mem[wrap(base, i)];
        end
        chk($sformatf("st_b%0h.nwrites", base), V'(write_cnt - wc0), V'(16));
        chk($sformatf("st_b%0h.mem", base), obsv, vec);
    endtask

    // Returns at the negedge of cycle 19 (idle), or early after a mid-load reset.
    task automatic do_load(input logic [AW-1:0] base, input logic [RW-1:0] raddr, input int reset_at);
        string t;
        logic [V-1:0] expv;
        for (int i = 0; i < NB; i++) expv[W*i +: W] = ref_mem[wrap(base, i)];
        op_store = 1'b0; base_address = base; reg_address = raddr; reg_rdata = rand_vec();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; base_address = AW'($urandom); reg_address = RW'($urandom); op_store = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            t = $sformatf("ld_b%0h_c%0d", base, k);
            if (k == reset_at) begin
                reset = 1'b1;
                #1 expect_zero({t, ".rst"});
                @(negedge clk);
                expect_zero({t, ".rst1"});
                reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    expect_out($sformatf("%s.post%0d", t, j), 0, 0, 0, 0, 0);
                end
                break;
            end
            if (k <= 16) begin
                expect_out(t, 1, 0, 0, 0, 1);
                chk({t, ".addr"}, V'(mem_address), V'(wrap(base, k - 1)));
            end else if (k == 17) begin
                expect_out(t, 0, 0, 0, 0, 1);
            end else if (k == 18) begin
                expect_out(t, 0, 0, 1, 1, 1);
                chk({t, ".waddr"}, V'(reg_waddr), V'(raddr));
                chk({t, ".wdata"}, reg_wdata, expv);
            end else begin
                expect_out(t, 0, 0, 0, 0, 0);
                chk({t, ".hold"}, reg_wdata, expv);
            end
        end
    endtask

    initial begin
        logic [V-1:0] v;
        reset = 1'b1; start = 1'b0; op_store = 1'b0;
        base_address = '0; reg_address = '0; reg_rdata = '0;
        for (int i = 0; i < 512; i++) poke(i, $urandom);
        @(negedge clk);
        expect_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        expect_zero("idle");

        for (int i = 0; i < NB; i++) v[W*i +: W] = 32'hA5A5_0000 + W'(i);
        do_store(9'h010, v, 1'b0);

        for (int i = 0; i < NB; i++) poke(9'h020 + i, W'(i * 3));
        @(negedge clk);
        do_load(9'h020, 2'd2, 0);

        v = rand_vec();
        do_store(9'h1F8, v, 1'b0);
        do_load(9'h1F8, 2'd1, 0);
        chk("wrap.roundtrip", reg_wdata, v);

        do_store(9'h0A0, rand_vec(), 1'b1);

        do_load(9'h0A0, 2'd3, 8);
        @(negedge clk);
        do_load(9'h0A0, 2'd3, 0);
        do_load(9'h020, 2'd0, 0);

        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) do_store(AW'($urandom), rand_vec(), 1'b0);
            else do_load(AW'($urandom), RW'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
